// File: rtl/dap_ahb_pkg.sv
// Shared types and constants for the debug AP slave-bus to AHB-Lite bridge.
package dap_ahb_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_RESP  = 3'd3,
    S_ERR   = 3'd4,
    S_DRAIN = 3'd5
  } state_e;

  localparam int         SLVTRANS_VALID_BIT = 1;
  localparam logic [1:0] HTRANS_IDLE        = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ      = 2'b10;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  localparam logic [3:0] HPROT_DEBUG = 4'b0011;

  // True when the size code is illegal or the address is not naturally aligned.
  function automatic logic req_illegal(logic [1:0] size, logic [1:0] addr_lo);
    logic bad;
    case (size)
      SIZE_BYTE:    bad = 1'b0;
      SIZE_HALF:    bad = addr_lo[0];
      SIZE_WORD:    bad = |addr_lo;
      SIZE_ILLEGAL: bad = 1'b1;
      default:      bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dap_ahb_timeout.sv
// AHB wait-state counter for the bridge; flags the TIMEOUT_CYCLES-th consecutive stall cycle.
// Only instantiated when DAPAHB_TIMEOUT_EN is defined.
module dap_ahb_timeout #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Fires during the stall cycle that brings the count up to TIMEOUT_CYCLES.
  assign expired = inc && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dap_slv_ahb_bridge.sv
// Debug AP slave-bus responder: re-issues one AP access at a time as a single AHB-Lite transfer.
// Optional AHB stall timeout with bus drain is enabled by defining DAPAHB_TIMEOUT_EN.
module dap_slv_ahb_bridge #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic        DCLK,
  input  logic        APRESETn,
  input  logic        DEVICEEN,
  input  logic [31:0] SLVADDR,
  input  logic [31:0] SLVWDATA,
  input  logic [1:0]  SLVTRANS,
  input  logic        SLVWRITE,
  input  logic [1:0]  SLVSIZE,
  output logic [31:0] SLVRDATA,
  output logic        SLVREADY,
  output logic        SLVRESP,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  import dap_ahb_pkg::*;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        tmo_q, tmo_d;

  logic        tmo_clr;
  logic        tmo_inc;
  logic        tmo_expired;
  logic        slv_ready;
  logic        unused_trans0;

  assign unused_trans0 = SLVTRANS[0];

`ifdef DAPAHB_TIMEOUT_EN
  dap_ahb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timeout (
    .clk    (DCLK),
    .rst_n  (APRESETn),
    .clr    (tmo_clr),
    .inc    (tmo_inc),
    .expired(tmo_expired)
  );
`else
  logic unused_tmo;
  assign unused_tmo  = tmo_clr ^ tmo_inc ^ (TIMEOUT_CYCLES > 0) ^ (CNT_W > 0);
  assign tmo_expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    size_d  = size_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    tmo_clr = 1'b0;
    tmo_inc = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (SLVTRANS[SLVTRANS_VALID_BIT]) begin
          addr_d  = SLVADDR;
          wdata_d = SLVWDATA;
          write_d = SLVWRITE;
          size_d  = SLVSIZE;
          rdata_d = '0;
          tmo_d   = 1'b0;
          if (!DEVICEEN || req_illegal(SLVSIZE, SLVADDR[1:0])) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else begin
            err_d   = 1'b0;
            tmo_clr = 1'b1;
            state_d = S_ADDR;
          end
        end
      end

      // NONSEQ is held here while an earlier transfer's data phase stalls the bus.
      S_ADDR: begin
        if (HREADY) begin
          state_d = S_DATA;
        end else begin
          tmo_inc = 1'b1;
          if (tmo_expired) begin
            err_d   = 1'b1;
            rdata_d = '0;
            tmo_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end

      // The first cycle of a two-cycle ERROR has HREADY low and is absorbed as a wait.
      S_DATA: begin
        if (HREADY) begin
          err_d   = HRESP;
          rdata_d = (write_q || HRESP) ? '0 : HRDATA;
          state_d = S_RESP;
        end else begin
          tmo_inc = 1'b1;
          if (tmo_expired) begin
            err_d   = 1'b1;
            rdata_d = '0;
            tmo_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end

      S_RESP: begin
        state_d = tmo_q ? S_DRAIN : S_IDLE;
      end

      S_ERR: begin
        state_d = S_IDLE;
      end

      // The abandoned transfer still owns the bus until the slave finally completes it.
      S_DRAIN: begin
        if (HREADY) begin
          tmo_d   = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge DCLK or negedge APRESETn) begin
    if (!APRESETn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      size_q  <= 2'b00;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      size_q  <= size_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  assign slv_ready = (state_q == S_RESP) || (state_q == S_ERR);

  assign SLVREADY = slv_ready;
  assign SLVRESP  = slv_ready & err_q;
  assign SLVRDATA = slv_ready ? rdata_q : '0;

  assign HTRANS = (state_q == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR  = addr_q;
  assign HWRITE = write_q;
  assign HSIZE  = {1'b0, size_q};
  assign HPROT  = HPROT_DEBUG;
  assign HWDATA = wdata_q;

endmodule

// File: tb/tb_dap_slv_ahb_bridge.sv
// Self-checking bench for dap_slv_ahb_bridge: directed spec cases plus randomized accesses
// against a transaction-level expectation model and a behavioural AHB slave.
module tb_dap_slv_ahb_bridge;

  localparam int TMO = 4;

  logic        DCLK = 1'b0;
  logic        APRESETn;
  logic        DEVICEEN;
  logic [31:0] SLVADDR;
  logic [31:0] SLVWDATA;
  logic [1:0]  SLVTRANS;
  logic        SLVWRITE;
  logic [1:0]  SLVSIZE;
  logic [31:0] SLVRDATA;
  logic        SLVREADY;
  logic        SLVRESP;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  int n_run  = 0;
  int n_fail = 0;

  always #5 DCLK = ~DCLK;

  dap_slv_ahb_bridge #(.TIMEOUT_CYCLES(TMO), .CNT_W(3)) dut (
    .DCLK(DCLK), .APRESETn(APRESETn), .DEVICEEN(DEVICEEN),
    .SLVADDR(SLVADDR), .SLVWDATA(SLVWDATA), .SLVTRANS(SLVTRANS),
    .SLVWRITE(SLVWRITE), .SLVSIZE(SLVSIZE), .SLVRDATA(SLVRDATA),
    .SLVREADY(SLVREADY), .SLVRESP(SLVRESP), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HPROT(HPROT), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  // One AP access with an AHB slave that stalls the address phase pre_stall cycles and the
  // data phase waits cycles. Cycle 0 is the negedge at which the request is first driven.
  task automatic do_xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                         input logic [1:0] size, input logic en, input int pre_stall,
                         input int waits, input logic ahb_err, input logic [31:0] hrdata,
                         input string tag);
    int          bytes;
    bit          local_err;
    int          exp_cyc;
    logic [31:0] exp_rdata;
    logic        exp_resp;
    int          nonseq_acc = 0;
    int          pre_cnt    = 0;
    int          dcnt       = 0;
    bit          in_data    = 0;
    int          got_cyc    = -1;
    logic [31:0] got_rdata  = '0;
    logic        got_resp   = 1'b0;

    bytes     = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    local_err = !en || (size == 2'b11) || ((addr % bytes) != 0);
    exp_cyc   = local_err ? 1 : 3 + pre_stall + waits;
    exp_resp  = local_err || ahb_err;
    exp_rdata = (local_err || wr || ahb_err) ? 32'h0 : hrdata;

    @(negedge DCLK);
    SLVADDR  = addr;
    SLVWDATA = wdata;
    SLVWRITE = wr;
    SLVSIZE  = size;
    DEVICEEN = en;
    SLVTRANS = {1'b1, 1'($urandom_range(0, 1))};
    HREADY   = 1'b1;
    HRESP    = 1'b0;

    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge DCLK);
      if (c > 0 && SLVREADY === 1'b1) begin
        got_cyc   = c;
        got_rdata = SLVRDATA;
        got_resp  = SLVRESP;
        n_run++;
        if (HTRANS !== 2'b00) begin
          n_fail++;
          $display("FAIL %s htrans_at_ready: got %b want 00", tag, HTRANS);
        end
        break;
      end
      if (c > 0) begin
        n_run++;
        if (SLVRDATA !== 32'h0 || SLVRESP !== 1'b0) begin
          n_fail++;
          $display("FAIL %s slv_idle_zero c%0d: rdata %h resp %b want 0/0", tag, c, SLVRDATA, SLVRESP);
        end
      end
      if (in_data) begin
        n_run++;
        if (HTRANS !== 2'b00 || (wr && HWDATA !== wdata)) begin
          n_fail++;
          $display("FAIL %s data_phase c%0d: htrans %b hwdata %h want 00/%h", tag, c, HTRANS, HWDATA, wdata);
        end
        if (dcnt < waits) begin
          HREADY = 1'b0;
          HRESP  = ahb_err && (dcnt == waits - 1);
          HRDATA = $urandom;
          dcnt++;
        end else begin
          HREADY  = 1'b1;
          HRESP   = ahb_err;
          HRDATA  = ahb_err ? $urandom : hrdata;
          in_data = 0;
        end
      end else if (HTRANS === 2'b10) begin
        n_run++;
        if (HADDR !== addr || HWRITE !== wr || HSIZE !== {1'b0, size} || HPROT !== 4'b0011) begin
          n_fail++;
          $display("FAIL %s addr_phase: haddr %h hwrite %b hsize %b hprot %b want %h/%b/%b/0011",
                   tag, HADDR, HWRITE, HSIZE, HPROT, addr, wr, {1'b0, size});
        end
        HRESP = 1'b0;
        if (pre_cnt < pre_stall) begin
          HREADY = 1'b0;
          pre_cnt++;
        end else begin
          HREADY  = 1'b1;
          nonseq_acc++;
          in_data = 1;
        end
      end else begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = $urandom;
      end
    end

    SLVTRANS = 2'b00;
    HREADY   = 1'b1;
    HRESP    = 1'b0;

    n_run++;
    if (got_cyc != exp_cyc) begin
      n_fail++;
      $display("FAIL %s ready_cycle: got %0d want %0d", tag, got_cyc, exp_cyc);
    end
    n_run++;
    if (got_resp !== exp_resp || got_rdata !== exp_rdata) begin
      n_fail++;
      $display("FAIL %s response: resp %b rdata %h want %b/%h", tag, got_resp, got_rdata, exp_resp, exp_rdata);
    end
    n_run++;
    if (nonseq_acc != (local_err ? 0 : 1)) begin
      n_fail++;
      $display("FAIL %s nonseq_count: got %0d want %0d", tag, nonseq_acc, local_err ? 0 : 1);
    end
  endtask

  task automatic test_reset();
    APRESETn = 1'b0;
    DEVICEEN = 1'b1;
    SLVADDR  = '0;
    SLVWDATA = '0;
    SLVTRANS = 2'b00;
    SLVWRITE = 1'b0;
    SLVSIZE  = 2'b00;
    HRDATA   = '0;
    HREADY   = 1'b1;
    HRESP    = 1'b0;
    repeat (3) @(negedge DCLK);
    n_run++;
    if (HTRANS !== 2'b00 || SLVREADY !== 1'b0 || SLVRESP !== 1'b0 || SLVRDATA !== 32'h0 ||
        HADDR !== 32'h0 || HWDATA !== 32'h0 || HWRITE !== 1'b0 || HSIZE !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_outputs: htrans %b ready %b resp %b rdata %h haddr %h hwdata %h hwrite %b hsize %b want all 0",
               HTRANS, SLVREADY, SLVRESP, SLVRDATA, HADDR, HWDATA, HWRITE, HSIZE);
    end
    n_run++;
    if (HPROT !== 4'b0011) begin
      n_fail++;
      $display("FAIL reset_hprot: got %b want 0011", HPROT);
    end
    APRESETn = 1'b1;
    @(negedge DCLK);
  endtask

  task automatic test_directed();
    do_xfer(32'h2000_0010, 32'h0, 1'b0, 2'b10, 1'b1, 0, 0, 1'b0, 32'hCAFE_F00D, "word_read");
    do_xfer(32'h4000_0003, 32'h0000_00A5, 1'b1, 2'b00, 1'b1, 0, 2, 1'b0, 32'h0, "byte_write_2ws");
    do_xfer(32'h2000_0002, 32'h0, 1'b0, 2'b01, 1'b1, 1, 1, 1'b0, 32'h1357_9BDF, "half_read_stalled");
  endtask

  task automatic test_local_err();
    do_xfer(32'h2000_0001, 32'h0, 1'b0, 2'b01, 1'b1, 0, 0, 1'b0, 32'h0, "half_misaligned");
    do_xfer(32'h2000_0000, 32'h0, 1'b0, 2'b11, 1'b1, 0, 0, 1'b0, 32'h0, "size_illegal");
    do_xfer(32'h2000_0000, 32'h0, 1'b0, 2'b10, 1'b0, 0, 0, 1'b0, 32'h0, "deviceen_low");
    do_xfer(32'h2000_0006, 32'h0, 1'b1, 2'b10, 1'b1, 0, 0, 1'b0, 32'h0, "word_misaligned");
  endtask

  task automatic test_ahb_error();
    do_xfer(32'h2000_0100, 32'h0, 1'b0, 2'b10, 1'b1, 0, 1, 1'b1, 32'hDEAD_BEEF, "ahb_err_read");
    do_xfer(32'h2000_0104, 32'h0, 1'b0, 2'b10, 1'b1, 0, 0, 1'b0, 32'h600D_DA7A, "after_err_read");
  endtask

  task automatic test_reset_mid();
    @(negedge DCLK);
    SLVADDR  = 32'h2000_0020;
    SLVWRITE = 1'b0;
    SLVSIZE  = 2'b10;
    DEVICEEN = 1'b1;
    SLVTRANS = 2'b10;
    HREADY   = 1'b1;
    @(negedge DCLK);
    n_run++;
    if (HTRANS !== 2'b10) begin
      n_fail++;
      $display("FAIL rst_mid_nonseq: got %b want 10", HTRANS);
    end
    @(negedge DCLK);
    HREADY = 1'b0;
    @(negedge DCLK);
    APRESETn = 1'b0;
    #1;
    n_run++;
    if (HTRANS !== 2'b00 || SLVREADY !== 1'b0 || HADDR !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid_immediate: htrans %b ready %b haddr %h want 00/0/0", HTRANS, SLVREADY, HADDR);
    end
    @(negedge DCLK);
    SLVTRANS = 2'b00;
    HREADY   = 1'b1;
    APRESETn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge DCLK);
      n_run++;
      if (SLVREADY !== 1'b0 || HTRANS !== 2'b00) begin
        n_fail++;
        $display("FAIL rst_mid_abandoned c%0d: ready %b htrans %b want 0/00", c, SLVREADY, HTRANS);
      end
    end
    do_xfer(32'h2000_0024, 32'h0, 1'b0, 2'b10, 1'b1, 0, 0, 1'b0, 32'hA5A5_0F0F, "rst_mid_clean_read");
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      logic        en;
      logic        er;
      int          pre;
      int          ws;
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      sz = 2'($urandom_range(0, 3));
      en = ($urandom_range(0, 9) != 0);
      er = ($urandom_range(0, 5) == 0);
      pre = $urandom_range(0, 1);
      ws  = $urandom_range(er ? 1 : 0, 2);
      do_xfer(a, $urandom, 1'($urandom_range(0, 1)), sz, en, pre, ws, er, $urandom, $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      do_xfer({$urandom_range(0, 32'h0FFF_FFFF), 4'h0}, $urandom, 1'(i % 2), 2'b10, 1'b1, 0, 0, 1'b0,
              $urandom, $sformatf("b2b%0d", i));
    end
  endtask

`ifdef DAPAHB_TIMEOUT_EN
  task automatic test_timeout();
    int first_ready  = -1;
    int second_ready = -1;
    int renonseq     = -1;
    logic r1_resp    = 1'b0;
    logic [31:0] r1_data = '0;
    logic r2_resp    = 1'b1;
    logic [31:0] r2_data = '0;
    @(negedge DCLK);
    SLVADDR  = 32'h2000_0040;
    SLVWRITE = 1'b0;
    SLVSIZE  = 2'b10;
    DEVICEEN = 1'b1;
    SLVTRANS = 2'b10;
    HREADY   = 1'b1;
    HRESP    = 1'b0;
    HRDATA   = 32'h1234_5678;
    for (int c = 1; c <= 20; c++) begin
      @(negedge DCLK);
      if (SLVREADY === 1'b1 && first_ready < 0) begin
        first_ready = c; r1_resp = SLVRESP; r1_data = SLVRDATA;
      end else if (SLVREADY === 1'b1 && second_ready < 0) begin
        second_ready = c; r2_resp = SLVRESP; r2_data = SLVRDATA;
        SLVTRANS = 2'b00;
      end
      if (c > 1 && HTRANS === 2'b10 && renonseq < 0) renonseq = c;
      HREADY = (c >= 2 && c <= 11) ? 1'b0 : 1'b1;
    end
    SLVTRANS = 2'b00;
    HREADY   = 1'b1;
    n_run++;
    if (first_ready != 2 + TMO || r1_resp !== 1'b1 || r1_data !== 32'h0) begin
      n_fail++;
      $display("FAIL timeout_resp: cycle %0d resp %b rdata %h want %0d/1/0", first_ready, r1_resp, r1_data, 2 + TMO);
    end
    n_run++;
    if (renonseq != 14) begin
      n_fail++;
      $display("FAIL timeout_drain_holdoff: next nonseq at %0d want 14", renonseq);
    end
    n_run++;
    if (second_ready != 16 || r2_resp !== 1'b0 || r2_data !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL timeout_next_read: cycle %0d resp %b rdata %h want 16/0/12345678", second_ready, r2_resp, r2_data);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_local_err();
    test_ahb_error();
    test_reset_mid();
    test_random();
    test_back_to_back();
`ifdef DAPAHB_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule
